// File: rtl/kt8_run_ctrl_pkg.sv
// Shared types and constants for the KT8 boot/run sequencer.
package kt8_run_ctrl_pkg;

  localparam int unsigned PM_AW = 8;
  localparam int unsigned PM_DW = 8;
  localparam int unsigned LCW   = 9;   // load count covers 0..256
  localparam int unsigned CCW   = 16;  // RUN cycle counter width
  localparam int unsigned RCW   = 16;  // core-reset cycle counter width

  localparam int unsigned DEF_RST_CYCLES  = 2;
  localparam int unsigned DEF_HALT_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT     = 65535;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RESET_CPU = 3'd2,
    ST_RUN       = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  typedef struct packed {
    logic             we;
    logic [PM_AW-1:0] addr;
    logic [PM_DW-1:0] data;
  } pm_wr_t;

endpackage

// File: rtl/kt8_run_ctrl_halt_detect.sv
// Watches the core PC during RUN: jump-to-self detection, RUN cycle count and timeout compare.
module kt8_run_ctrl_halt_detect
  import kt8_run_ctrl_pkg::*;
#(
  parameter int unsigned HALT_CYCLES = DEF_HALT_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PM_AW-1:0] pc_i,
  output logic             halt_hit_o,
  output logic             timeout_hit_o,
  output logic [CCW-1:0]   cycle_count_o
);

  localparam int unsigned SCW = 16;

  logic [PM_AW-1:0] prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;
  logic [SCW-1:0]   same_cnt_q, same_cnt_d;
  logic [CCW-1:0]   cyc_q, cyc_d;
  logic             pc_same;
  logic [SCW-1:0]   same_nxt;

  assign cycle_count_o = cyc_q;

  // The hit outputs are combinational so the FSM leaves RUN in the cycle the condition forms.
  always_comb begin
    prev_pc_d     = prev_pc_q;
    prev_vld_d    = prev_vld_q;
    same_cnt_d    = same_cnt_q;
    cyc_d         = cyc_q;
    same_nxt      = same_cnt_q + SCW'(1);
    pc_same       = prev_vld_q && (pc_i == prev_pc_q);
    halt_hit_o    = en_i && pc_same && (same_nxt == SCW'(HALT_CYCLES));
    timeout_hit_o = en_i && (TIMEOUT != 0) && (cyc_q == CCW'(TIMEOUT - 1));
    if (clr_i) begin
      prev_pc_d  = '0;
      prev_vld_d = 1'b0;
      same_cnt_d = '0;
      cyc_d      = '0;
    end else if (en_i) begin
      prev_pc_d  = pc_i;
      prev_vld_d = 1'b1;
      same_cnt_d = pc_same ? same_nxt : '0;
      // Count freezes on the cycle RUN ends so it reports completed cycles.
      if (!halt_hit_o && !timeout_hit_o && (cyc_q != {CCW{1'b1}})) begin
        cyc_d = cyc_q + CCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      same_cnt_q <= '0;
      cyc_q      <= '0;
    end else begin
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      same_cnt_q <= same_cnt_d;
      cyc_q      <= cyc_d;
    end
  end

endmodule

// File: rtl/kt8_run_ctrl.sv
// KT8 boot/run sequencer: streams a program into PM, then resets, releases and monitors the core.
module kt8_run_ctrl
  import kt8_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned HALT_CYCLES = DEF_HALT_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_start_i,
  input  logic             ld_valid_i,
  input  logic [PM_DW-1:0] ld_data_i,
  input  logic             ld_last_i,
  output logic             ld_ready_o,
  input  logic             run_i,
  input  logic             abort_i,
  input  logic [PM_AW-1:0] pc_i,
  output logic             pm_we_o,
  output logic [PM_AW-1:0] pm_addr_o,
  output logic [PM_DW-1:0] pm_data_o,
  output logic             cpu_rst_o,
  output logic [2:0]       state_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [LCW-1:0]   load_count_o,
  output logic [CCW-1:0]   cycle_count_o
);

  state_e           state_q, state_d;
  pm_wr_t           pm_q, pm_d;
  logic [PM_AW-1:0] addr_q, addr_d;
  logic [LCW-1:0]   load_cnt_q, load_cnt_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             ld_ready_q, ld_ready_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             xfer;
  logic             hd_clr, hd_en, halt_hit, timeout_hit;

  assign hd_clr = (state_q == ST_RESET_CPU);
  assign hd_en  = (state_q == ST_RUN) && !abort_i;

  kt8_run_ctrl_halt_detect #(
    .HALT_CYCLES (HALT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_halt_detect (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (hd_clr),
    .en_i          (hd_en),
    .pc_i          (pc_i),
    .halt_hit_o    (halt_hit),
    .timeout_hit_o (timeout_hit),
    .cycle_count_o (cycle_count_o)
  );

  assign ld_ready_o   = ld_ready_q;
  assign pm_we_o      = pm_q.we;
  assign pm_addr_o    = pm_q.addr;
  assign pm_data_o    = pm_q.data;
  assign cpu_rst_o    = cpu_rst_q;
  assign state_o      = 3'(state_q);
  assign halted_o     = halted_q;
  assign timeout_o    = timeout_q;
  assign load_count_o = load_cnt_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    pm_d       = pm_q;
    pm_d.we    = 1'b0;
    addr_d     = addr_q;
    load_cnt_d = load_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    ld_ready_d = ld_ready_q;
    cpu_rst_d  = cpu_rst_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    xfer       = ld_valid_i && ld_ready_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        cpu_rst_d  = 1'b1;
        ld_ready_d = 1'b0;
        if (ld_start_i) begin
          state_d    = ST_LOAD;
          ld_ready_d = 1'b1;
          addr_d     = '0;
          load_cnt_d = '0;
          halted_d   = 1'b0;
          timeout_d  = 1'b0;
        end else if (run_i) begin
          state_d   = ST_RESET_CPU;
          rst_cnt_d = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          state_d    = ST_IDLE;
          ld_ready_d = 1'b0;
        end else if (xfer) begin
          pm_d.we    = 1'b1;
          pm_d.addr  = addr_q;
          pm_d.data  = ld_data_i;
          load_cnt_d = load_cnt_q + LCW'(1);
          // The 256th byte ends the load even without ld_last_i; addr never wraps.
          if (ld_last_i || (addr_q == {PM_AW{1'b1}})) begin
            state_d    = ST_IDLE;
            ld_ready_d = 1'b0;
          end else begin
            addr_d = addr_q + PM_AW'(1);
          end
        end
      end
      ST_RESET_CPU: begin
        cpu_rst_d = 1'b1;
        if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = ST_RUN;
          cpu_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      ST_RUN: begin
        cpu_rst_d = 1'b0;
        if (abort_i) begin
          state_d   = ST_HALT;
          cpu_rst_d = 1'b1;
        end else if (halt_hit || timeout_hit) begin
          state_d   = ST_HALT;
          cpu_rst_d = 1'b1;
          halted_d  = halt_hit;
          timeout_d = timeout_hit;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cpu_rst_d  = 1'b1;
        ld_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pm_q       <= '0;
      addr_q     <= '0;
      load_cnt_q <= '0;
      rst_cnt_q  <= '0;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pm_q       <= pm_d;
      addr_q     <= addr_d;
      load_cnt_q <= load_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_kt8_run_ctrl.sv
// Directed bench for kt8_run_ctrl: one instance with default parameters, one with TIMEOUT=10, shared stimulus.
module tb_kt8_run_ctrl;

  logic       clk = 1'b0;
  logic       rst, ld_start, ld_valid, ld_last, run, abort;
  logic [7:0] ld_data, pc;

  logic        a_ready, a_we, a_cpu_rst, a_halted, a_timeout;
  logic [7:0]  a_addr, a_data;
  logic [2:0]  a_state;
  logic [8:0]  a_lcnt;
  logic [15:0] a_ccnt;
  logic        b_ready, b_we, b_cpu_rst, b_halted, b_timeout;
  logic [7:0]  b_addr, b_data;
  logic [2:0]  b_state;
  logic [8:0]  b_lcnt;
  logic [15:0] b_ccnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kt8_run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .ld_start_i(ld_start), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(a_ready), .run_i(run),
    .abort_i(abort), .pc_i(pc), .pm_we_o(a_we), .pm_addr_o(a_addr), .pm_data_o(a_data),
    .cpu_rst_o(a_cpu_rst), .state_o(a_state), .halted_o(a_halted), .timeout_o(a_timeout),
    .load_count_o(a_lcnt), .cycle_count_o(a_ccnt)
  );

  kt8_run_ctrl #(.TIMEOUT(10)) dut_to (
    .clk_i(clk), .rst_i(rst), .ld_start_i(ld_start), .ld_valid_i(ld_valid),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(b_ready), .run_i(run),
    .abort_i(abort), .pc_i(pc), .pm_we_o(b_we), .pm_addr_o(b_addr), .pm_data_o(b_data),
    .cpu_rst_o(b_cpu_rst), .state_o(b_state), .halted_o(b_halted), .timeout_o(b_timeout),
    .load_count_o(b_lcnt), .cycle_count_o(b_ccnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] bytes [4];
    int writes, first_idle, last_addr, last_data;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

    // 1. reset
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; run = 1'b0;
    abort = 1'b0; ld_data = 8'h00; pc = 8'h00;
    tick(); tick(); tick();
    chk("rst_state", 32'(a_state), 32'd0);
    chk("rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_lcnt", 32'(a_lcnt), 32'd0);
    chk("rst_ccnt", 32'(a_ccnt), 32'd0);
    chk("rst_flags", 32'({a_halted, a_timeout}), 32'd0);
    chk("rst_addr_data", 32'({a_addr, a_data}), 32'd0);
    rst = 1'b0;

    // 2. four-byte load with ld_last on the final byte
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("ld4_state_load", 32'(a_state), 32'd1);
    chk("ld4_ready", 32'(a_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = bytes[i]; ld_last = (i == 3);
      tick();
      chk("ld4_we", 32'(a_we), 32'd1);
      chk("ld4_addr", 32'(a_addr), 32'(i));
      chk("ld4_data", 32'(a_data), 32'(bytes[i]));
      chk("ld4_lcnt", 32'(a_lcnt), 32'(i + 1));
      chk("ld4_state", 32'(a_state), (i == 3) ? 32'd0 : 32'd1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld4_ready_low", 32'(a_ready), 32'd0);
    tick();
    chk("ld4_we_low", 32'(a_we), 32'd0);

    // 3. 300 bytes without ld_last: stops after 256 writes
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    writes = 0; first_idle = -1; last_addr = -1; last_data = -1;
    for (int i = 0; i < 300; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5A;
      tick();
      if (a_we) begin
        writes++; last_addr = int'(a_addr); last_data = int'(a_data);
      end
      if (a_state == 3'd0 && first_idle < 0) first_idle = i;
    end
    ld_valid = 1'b0;
    chk("ld256_writes", 32'(writes), 32'd256);
    chk("ld256_last_addr", 32'(last_addr), 32'd255);
    chk("ld256_last_data", 32'(last_data), 32'hA5);
    chk("ld256_idle_at", 32'(first_idle), 32'd255);
    chk("ld256_ready_low", 32'(a_ready), 32'd0);
    chk("ld256_lcnt", 32'(a_lcnt), 32'd256);

    // 4. run to a jump-to-self halt
    run = 1'b1; tick(); run = 1'b0;
    chk("run_state_rstcpu", 32'(a_state), 32'd2);
    chk("run_cpu_rst_hi", 32'(a_cpu_rst), 32'd1);
    tick();
    chk("run_cpu_rst_hi2", 32'(a_cpu_rst), 32'd1);
    tick();
    chk("run_state_run", 32'(a_state), 32'd3);
    chk("run_cpu_rst_lo", 32'(a_cpu_rst), 32'd0);
    pc = 8'd0; tick(); pc = 8'd1; tick(); pc = 8'd2; tick();
    pc = 8'd3; tick(); pc = 8'd3; tick();
    chk("jself_still_run", 32'(a_state), 32'd3);
    pc = 8'd3; tick();
    chk("jself_state", 32'(a_state), 32'd4);
    chk("jself_halted", 32'(a_halted), 32'd1);
    chk("jself_timeout", 32'(a_timeout), 32'd0);
    chk("jself_cpu_rst", 32'(a_cpu_rst), 32'd1);
    chk("jself_ccnt", 32'(a_ccnt), 32'd5);
    tick();
    chk("jself_sticky", 32'({a_state, a_halted}), 32'({3'd4, 1'b1}));

    // 5. timeout with incrementing pc (TIMEOUT=10 instance)
    run = 1'b1; tick(); run = 1'b0;
    chk("to_flags_cleared", 32'({a_halted, b_halted}), 32'd0);
    tick(); tick();
    chk("to_state_run", 32'(b_state), 32'd3);
    for (int k = 0; k < 10; k++) begin
      pc = 8'(10 + k);
      tick();
      if (k == 8) chk("to_still_run", 32'(b_state), 32'd3);
    end
    chk("to_state", 32'(b_state), 32'd4);
    chk("to_timeout", 32'(b_timeout), 32'd1);
    chk("to_halted", 32'(b_halted), 32'd0);
    chk("to_ccnt", 32'(b_ccnt), 32'd9);
    chk("to_default_run", 32'(a_state), 32'd3);
    chk("to_default_ccnt", 32'(a_ccnt), 32'd10);

    // 6a. abort in RUN -> HALT with no flags; abort ignored in HALT
    abort = 1'b1; pc = 8'd20; tick(); abort = 1'b0;
    chk("abort_run_state", 32'(a_state), 32'd4);
    chk("abort_run_flags", 32'({a_halted, a_timeout}), 32'd0);
    chk("abort_halt_ign", 32'({b_state, b_timeout}), 32'({3'd4, 1'b1}));
    run = 1'b1; tick(); run = 1'b0;
    chk("rerun_state", 32'(b_state), 32'd2);
    chk("rerun_flags", 32'({b_halted, b_timeout}), 32'd0);
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort2_state", 32'(a_state), 32'd4);

    // 6b. ld_start wins over run_i; abort in LOAD drops the coincident byte
    ld_start = 1'b1; run = 1'b1; tick(); ld_start = 1'b0; run = 1'b0;
    chk("start_wins", 32'(a_state), 32'd1);
    ld_valid = 1'b1; ld_data = 8'hAA; tick();
    ld_data = 8'hBB; tick();
    chk("abld_we1", 32'({a_we, a_addr, a_data}), 32'({1'b1, 8'd1, 8'hBB}));
    ld_data = 8'hCC; abort = 1'b1; tick(); abort = 1'b0; ld_valid = 1'b0;
    chk("abld_no_write", 32'(a_we), 32'd0);
    chk("abld_state", 32'(a_state), 32'd0);
    chk("abld_ready", 32'(a_ready), 32'd0);
    chk("abld_lcnt", 32'(a_lcnt), 32'd2);

    // reset mid-load returns to the reset state
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; rst = 1'b1; tick(); rst = 1'b0; ld_valid = 1'b0;
    chk("midrst_state", 32'(a_state), 32'd0);
    chk("midrst_outs", 32'({a_ready, a_we, a_cpu_rst, a_lcnt}), 32'({1'b0, 1'b0, 1'b1, 9'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
